// File: rtl/rad4_mac_ctrl.sv
// rtl/rad4_mac_ctrl.sv - handshaked multiply-accumulate sequencer around the iterative radix-4 multiplier
module rad4_mac_ctrl #(
  parameter int DIGITS   = 128,
  parameter int MULT_LAT = 130,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DIGITS-1:0]   in_x,
  input  logic [2*DIGITS-1:0]   in_y,
  input  logic                  in_clr,
  output logic [2*DIGITS-1:0]   mul_x,
  output logic [2*DIGITS-1:0]   mul_y,
  output logic                  mul_en,
  output logic                  mul_rst_n,
  input  logic [4*DIGITS-1:0]   mul_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*DIGITS-1:0]   res_acc,
  output logic                  res_ovf,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                clr_q;
  logic [4*DIGITS-1:0] acc;
  logic                ovf;
  logic [4*DIGITS-1:0] acc_base;
  logic [4*DIGITS:0]   acc_sum;
  logic                cnt_last;

  // in_clr restarts the accumulation: the base term and the sticky flag both drop
  assign acc_base = clr_q ? '0 : acc;
  assign acc_sum  = {1'b0, acc_base} + {1'b0, mul_out};
  assign cnt_last = (cnt == CNT_W'(MULT_LAT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      mul_x <= '0;
      mul_y <= '0;
      clr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_x <= in_x;
            mul_y <= in_y;
            clr_q <= in_clr;
          end
        end
        CLR: cnt <= '0;
        RUN: cnt <= cnt + CNT_W'(1);
        ACC: begin
          acc <= acc_sum[4*DIGITS-1:0];
          ovf <= (clr_q ? 1'b0 : ovf) | acc_sum[4*DIGITS];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_en    = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CLR;
      end
      CLR: state_nxt = RUN;
      RUN: begin
        mul_en = 1'b1;
        if (cnt_last) state_nxt = ACC;
      end
      ACC: state_nxt = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplier reset follows controller reset combinationally so an abort clears it too
  assign mul_rst_n = rst_n & (state != CLR);
  assign busy      = (state != IDLE);
  assign res_acc   = acc;
  assign res_ovf   = ovf;

endmodule

// File: tb/tb_rad4_mac_ctrl.sv
// tb/tb_rad4_mac_ctrl.sv - directed bench for rad4_mac_ctrl with a latency-accurate multiplier model
module tb_rad4_mac_ctrl;

  localparam int DIGITS   = 4;
  localparam int MULT_LAT = 4;
  localparam int CNT_W    = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [2*DIGITS-1:0] in_x, in_y;
  logic                in_clr;
  logic [2*DIGITS-1:0] mul_x, mul_y;
  logic                mul_en;
  logic                mul_rst_n;
  logic [4*DIGITS-1:0] mul_out;
  logic                res_valid;
  logic                res_ready;
  logic [4*DIGITS-1:0] res_acc;
  logic                res_ovf;
  logic                busy;

  int compared = 0;
  int mismatched = 0;

  rad4_mac_ctrl #(.DIGITS(DIGITS), .MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_clr(in_clr),
    .mul_x(mul_x), .mul_y(mul_y), .mul_en(mul_en), .mul_rst_n(mul_rst_n), .mul_out(mul_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc), .res_ovf(res_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Product is only meaningful after MULT_LAT enabled cycles; before that it shows a poison pattern
  int mcnt;
  always @(posedge clk) begin
    if (!mul_rst_n) mcnt <= 0;
    else if (mul_en && mcnt < 1000) mcnt <= mcnt + 1;
  end
  assign mul_out = (mcnt >= MULT_LAT) ? (16'(mul_x) * 16'(mul_y)) : 16'hA5A5;

  task automatic run_txn(input logic [7:0] x, input logic [7:0] y, input logic clr,
                         input logic [15:0] exp_acc, input logic exp_ovf,
                         input int hold, input string name);
    int lat, en_cnt, en_rises, rst_low;
    logic prev_en, op_bad, busy_bad, hold_bad;
    lat = 0; en_cnt = 0; en_rises = 0; rst_low = 0;
    prev_en = 1'b0; op_bad = 1'b0; busy_bad = 1'b0; hold_bad = 1'b0;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s idle_ready: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; in_x = x; in_y = y; in_clr = clr;
    @(negedge clk);
    in_valid = 1'b0; in_x = ~x; in_y = ~y; in_clr = ~clr;
    while (res_valid !== 1'b1 && lat < 50) begin
      if (mul_en === 1'b1) begin
        en_cnt++;
        if (!prev_en) en_rises++;
      end
      prev_en = mul_en;
      if (mul_rst_n === 1'b0) rst_low++;
      if (mul_x !== x || mul_y !== y) op_bad = 1'b1;
      if (busy !== 1'b1 || in_ready !== 1'b0) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    compared++;
    if (lat != MULT_LAT + 2) begin
      mismatched++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, MULT_LAT + 2);
    end
    compared++;
    if (en_cnt != MULT_LAT || en_rises != 1) begin
      mismatched++;
      $display("FAIL %s mul_en: got %0d cycles in %0d runs want %0d in 1", name, en_cnt, en_rises, MULT_LAT);
    end
    compared++;
    if (rst_low != 1) begin
      mismatched++;
      $display("FAIL %s mul_rst_n_low: got %0d want 1", name, rst_low);
    end
    compared++;
    if (op_bad !== 1'b0 || busy_bad !== 1'b0) begin
      mismatched++;
      $display("FAIL %s operands_busy: op_bad %b busy_bad %b want 0 0", name, op_bad, busy_bad);
    end
    compared++;
    if (res_acc !== exp_acc || res_ovf !== exp_ovf) begin
      mismatched++;
      $display("FAIL %s result: got acc %0d ovf %b want acc %0d ovf %b", name, res_acc, res_ovf, exp_acc, exp_ovf);
    end
    if (hold > 0) begin
      in_valid = 1'b1; in_x = 8'h33; in_y = 8'h44; in_clr = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || res_acc !== exp_acc || in_ready !== 1'b0 ||
            mul_en !== 1'b0 || mul_x !== x || mul_y !== y) hold_bad = 1'b1;
      end
      in_valid = 1'b0;
      compared++;
      if (hold_bad !== 1'b0) begin
        mismatched++;
        $display("FAIL %s hold: state disturbed while res_ready low, got %b want 0", name, hold_bad);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res_acc !== exp_acc) begin
      mismatched++;
      $display("FAIL %s release: got ready %b valid %b busy %b acc %0d want 1 0 0 %0d",
               name, in_ready, res_valid, busy, res_acc, exp_acc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_clr = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (mul_rst_n !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mul_rst_n: got %b want 0", mul_rst_n);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || mul_en !== 1'b0 ||
        mul_rst_n !== 1'b1 || res_acc !== 16'd0 || res_ovf !== 1'b0 ||
        mul_x !== 8'd0 || mul_y !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_state: got ready %b busy %b valid %b en %b mrst %b acc %0d ovf %b x %0d y %0d want 1 0 0 0 1 0 0 0 0",
               in_ready, busy, res_valid, mul_en, mul_rst_n, res_acc, res_ovf, mul_x, mul_y);
    end
  endtask

  task automatic test_basic();
    run_txn(8'd10, 8'd5, 1'b1, 16'd50, 1'b0, 0, "basic_10x5");
  endtask

  task automatic test_accumulate();
    run_txn(8'd3, 8'd7, 1'b0, 16'd71, 1'b0, 0, "acc_3x7");
    run_txn(8'd2, 8'd2, 1'b1, 16'd4, 1'b0, 0, "clr_2x2");
  endtask

  task automatic test_overflow();
    run_txn(8'd255, 8'd255, 1'b1, 16'd65025, 1'b0, 0, "ovf_first");
    run_txn(8'd255, 8'd255, 1'b0, 16'd64514, 1'b1, 0, "ovf_wrap");
    run_txn(8'd1, 8'd1, 1'b0, 16'd64515, 1'b1, 0, "ovf_sticky");
    run_txn(8'd1, 8'd1, 1'b1, 16'd1, 1'b0, 0, "ovf_clear");
  endtask

  task automatic test_back_to_back_hold();
    run_txn(8'd9, 8'd9, 1'b1, 16'd81, 1'b0, 10, "hold_9x9");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd3; in_clr = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (mul_en !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL midrun_running: got en %b busy %b want 1 1", mul_en, busy);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (mul_rst_n !== 1'b0) begin
      mismatched++;
      $display("FAIL midrun_mul_rst_n: got %b want 0", mul_rst_n);
    end
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || mul_en !== 1'b0 || res_valid !== 1'b0 ||
        res_acc !== 16'd0 || res_ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL midrun_abort: got ready %b busy %b en %b valid %b acc %0d ovf %b want 1 0 0 0 0 0",
               in_ready, busy, mul_en, res_valid, res_acc, res_ovf);
    end
    rst_n = 1'b1;
    run_txn(8'd6, 8'd7, 1'b1, 16'd42, 1'b0, 0, "after_abort_6x7");
  endtask

  task automatic test_waveform();
    run_txn(8'd12, 8'd13, 1'b0, 16'd198, 1'b0, 0, "wave_12x13");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_overflow();
    test_back_to_back_hold();
    test_reset_mid_run();
    test_waveform();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
